// File: rtl/sync_fifo_prog_if.sv
// Handshake/data bundle for sync_fifo_prog.
// master: producer/consumer side driving requests; slave: the FIFO itself.
interface sync_fifo_prog_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = $clog2(FIFO_DEPTH)
);
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [ADDR_W:0]       count;

  modport master (
    output data_in, wr_en, rd_en,
    input  data_out, wr_ack, overflow, underflow,
    input  full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  data_in, wr_en, rd_en,
    output data_out, wr_ack, overflow, underflow,
    output full, empty, almostfull, almostempty, count
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with arbitrary depth (power of two not
// required), programmable almost-full/almost-empty levels and exported count.
// A write is accepted while full if a read is accepted in the same cycle.
// Build option SYNC_FIFO_FWFT_EN: first-word-fall-through read port
// (head word shown combinationally, 0 when empty). Without it, reads have a
// one-cycle registered latency and data_out holds between reads.
module sync_fifo_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  sync_fifo_prog_if.slave   bus
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  AF_CNT    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0]  AE_CNT    = CNT_W'(AE_LEVEL);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg;
  logic              wr_ack_reg;
  logic              overflow_reg;
  logic              underflow_reg;
  logic              is_full;
  logic              is_empty;
  logic              wr_accept;
  logic              rd_accept;

  assign is_full  = (count_reg == DEPTH_CNT);
  assign is_empty = (count_reg == '0);

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign wr_accept = bus.wr_en && (!is_full || bus.rd_en);
  assign rd_accept = bus.rd_en && !is_empty;

  // Pointer increment with explicit wrap so non-power-of-two depths work.
  always_comb begin
    wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + ADDR_W'(1);
    rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + ADDR_W'(1);
  end

  // Pointers, occupancy and single-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      wr_ack_reg    <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr_reg <= wr_ptr_next;
      if (rd_accept) rd_ptr_reg <= rd_ptr_next;
      unique case ({wr_accept, rd_accept})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      wr_ack_reg    <= wr_accept;
      overflow_reg  <= bus.wr_en && !wr_accept;
      underflow_reg <= bus.rd_en && !rd_accept;
    end
  end

  // Storage write; contents are never cleared, reset only discards them.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem[wr_ptr_reg] <= bus.data_in;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly; a pop exposes the next word after the edge.
  assign bus.data_out = is_empty ? '0 : mem[rd_ptr_reg];
`else
  logic [FIFO_WIDTH-1:0] data_out_reg;

  // Registered read port; holds the last word when nothing is popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_reg <= '0;
    end else if (rd_accept) begin
      data_out_reg <= mem[rd_ptr_reg];
    end
  end

  assign bus.data_out = data_out_reg;
`endif

  assign bus.wr_ack      = wr_ack_reg;
  assign bus.overflow    = overflow_reg;
  assign bus.underflow   = underflow_reg;
  assign bus.full        = is_full;
  assign bus.empty       = is_empty;
  assign bus.almostfull  = (count_reg >= AF_CNT) && !is_full;
  assign bus.almostempty = (count_reg <= AE_CNT) && !is_empty;
  assign bus.count       = count_reg;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: depth-8 default instance plus a
// depth-6 instance (AF_LEVEL=4, AE_LEVEL=2) for non-power-of-two wrapping.
// Expectations follow SYNC_FIFO_FWFT_EN when the bench is built with it.
module tb_sync_fifo_prog;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sync_fifo_prog_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) bus8 ();
  sync_fifo_prog_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(6)) bus6 ();

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(6), .AF_LEVEL(4), .AE_LEVEL(2)) u_dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Depth-6 interleaved sequence: hand-computed count after each op and the
  // write index returned by each read (0 = no read).
  int t_wr  [20] = '{1,1,1,1,1,1,1,0,0,0,1,1,1,0,0,0,0,1,0,0};
  int t_rd  [20] = '{0,0,0,0,0,0,1,1,1,1,0,0,1,1,1,1,1,0,1,1};
  int t_cnt [20] = '{1,2,3,4,5,6,6,5,4,3,4,5,5,4,3,2,1,2,1,0};
  int t_rdv [20] = '{0,0,0,0,0,0,1,2,3,4,0,0,5,6,7,8,9,0,10,11};
  int drain [8]  = '{2,3,4,5,6,7,8,'hAA};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op8(input logic wr, input logic rd, input logic [15:0] din);
    bus8.wr_en   = wr;
    bus8.rd_en   = rd;
    bus8.data_in = din;
    tick();
    $display("d8 wr=%0b rd=%0b din=%h -> count=%0d data_out=%h ack=%0b ovf=%0b udf=%0b",
             wr, rd, din, bus8.count, bus8.data_out, bus8.wr_ack, bus8.overflow, bus8.underflow);
  endtask

  task automatic op6(input logic wr, input logic rd, input logic [15:0] din);
    bus6.wr_en   = wr;
    bus6.rd_en   = rd;
    bus6.data_in = din;
    tick();
    $display("d6 wr=%0b rd=%0b din=%h -> count=%0d data_out=%h",
             wr, rd, din, bus6.count, bus6.data_out);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wk;
    wk = 0;

    // Reset held two cycles with requests active.
    rst = 1'b1;
    bus8.wr_en = 1'b1; bus8.rd_en = 1'b1; bus8.data_in = 16'h5555;
    bus6.wr_en = 1'b0; bus6.rd_en = 1'b0; bus6.data_in = 16'h0000;
    tick();
    tick();
    check("rst count",     bus8.count, 0);
    check("rst empty",     bus8.empty, 1);
    check("rst full",      bus8.full, 0);
    check("rst af",        bus8.almostfull, 0);
    check("rst ae",        bus8.almostempty, 0);
    check("rst data_out",  bus8.data_out, 0);
    check("rst wr_ack",    bus8.wr_ack, 0);
    check("rst overflow",  bus8.overflow, 0);
    check("rst underflow", bus8.underflow, 0);
    check("rst d6 empty",  bus6.empty, 1);
    rst = 1'b0;

    // Fill to full.
    for (int i = 1; i <= 8; i++) begin
      op8(1'b1, 1'b0, 16'(i));
      check("fill wr_ack", bus8.wr_ack, 1);
      check("fill count",  bus8.count, i);
      if (i == 1) begin
        check("fill ae@1",    bus8.almostempty, 1);
        check("fill empty@1", bus8.empty, 0);
      end
      if (i == 2) check("fill ae@2", bus8.almostempty, 0);
      if (i == 7) begin
        check("fill af@7",   bus8.almostfull, 1);
        check("fill full@7", bus8.full, 0);
      end
      if (i == 8) begin
        check("fill full@8", bus8.full, 1);
        check("fill af@8",   bus8.almostfull, 0);
      end
    end

    // Write alone while full is rejected.
    op8(1'b1, 1'b0, 16'h0009);
    check("ovf overflow", bus8.overflow, 1);
    check("ovf wr_ack",   bus8.wr_ack, 0);
    check("ovf count",    bus8.count, 8);

    // Simultaneous read and write while full.
`ifdef SYNC_FIFO_FWFT_EN
    check("full head", bus8.data_out, 16'h0001);
`endif
    op8(1'b1, 1'b1, 16'h00AA);
    check("fullrw count",    bus8.count, 8);
    check("fullrw overflow", bus8.overflow, 0);
    check("fullrw wr_ack",   bus8.wr_ack, 1);
    check("fullrw full",     bus8.full, 1);
`ifdef SYNC_FIFO_FWFT_EN
    check("fullrw data_out", bus8.data_out, 16'h0002);
`else
    check("fullrw data_out", bus8.data_out, 16'h0001);
`endif

    // Drain: order preserved, 0x00AA last after the write pointer wrapped.
    for (int k = 0; k < 8; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
      check("drain head", bus8.data_out, drain[k]);
`endif
      op8(1'b0, 1'b1, 16'h0000);
`ifndef SYNC_FIFO_FWFT_EN
      check("drain data", bus8.data_out, drain[k]);
`endif
      check("drain count", bus8.count, 7 - k);
    end
    check("drained empty", bus8.empty, 1);
    check("drained ae",    bus8.almostempty, 0);

    // Read on empty.
    op8(1'b0, 1'b1, 16'h0000);
    check("udf underflow", bus8.underflow, 1);
    check("udf count",     bus8.count, 0);
`ifdef SYNC_FIFO_FWFT_EN
    check("udf data_out",  bus8.data_out, 0);
`else
    check("udf data_out",  bus8.data_out, 16'h00AA);
`endif

    // Read and write on empty: write taken, read rejected.
    op8(1'b1, 1'b1, 16'h1234);
    check("erw underflow", bus8.underflow, 1);
    check("erw wr_ack",    bus8.wr_ack, 1);
    check("erw count",     bus8.count, 1);
    check("erw ae",        bus8.almostempty, 1);
    check("erw empty",     bus8.empty, 0);
`ifdef SYNC_FIFO_FWFT_EN
    check("erw data_out",  bus8.data_out, 16'h1234);
`else
    check("erw data_out",  bus8.data_out, 16'h00AA);
`endif

    op8(1'b0, 1'b1, 16'h0000);
    check("pop1 empty",     bus8.empty, 1);
    check("pop1 underflow", bus8.underflow, 0);
`ifdef SYNC_FIFO_FWFT_EN
    check("pop1 data_out",  bus8.data_out, 0);
    op8(1'b1, 1'b0, 16'h0BEE);
    check("fwft show",      bus8.data_out, 16'h0BEE);
    check("fwft count",     bus8.count, 1);
    op8(1'b0, 1'b1, 16'h0000);
    check("fwft pop empty", bus8.empty, 1);
    check("fwft pop data",  bus8.data_out, 0);
`else
    check("pop1 data_out",  bus8.data_out, 16'h1234);
    op8(1'b0, 1'b0, 16'h0000);
    check("hold data_out",  bus8.data_out, 16'h1234);
    check("hold wr_ack",    bus8.wr_ack, 0);
`endif

    // Reset mid-burst overrides active requests.
    op8(1'b1, 1'b0, 16'h0101);
    op8(1'b1, 1'b0, 16'h0202);
    op8(1'b1, 1'b1, 16'h0303);
    rst = 1'b1;
    bus8.wr_en = 1'b1; bus8.rd_en = 1'b1; bus8.data_in = 16'h0404;
    tick();
    check("mrst count",    bus8.count, 0);
    check("mrst empty",    bus8.empty, 1);
    check("mrst data_out", bus8.data_out, 0);
    check("mrst wr_ack",   bus8.wr_ack, 0);
    rst = 1'b0;
    op8(1'b0, 1'b0, 16'h0000);
    check("mrst after count", bus8.count, 0);

    // Depth 6: interleaved traffic, pointers wrap 5->0.
    for (int k = 0; k < 20; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
      if (t_rdv[k] != 0) check("d6 head", bus6.data_out, 32'h6000 + t_rdv[k]);
`endif
      if (t_wr[k] != 0) wk++;
      op6(t_wr[k] != 0, t_rd[k] != 0, 16'(32'h6000 + wk));
      check("d6 count",     bus6.count, t_cnt[k]);
      check("d6 full",      bus6.full, t_cnt[k] == 6);
      check("d6 empty",     bus6.empty, t_cnt[k] == 0);
      check("d6 af",        bus6.almostfull, t_cnt[k] >= 4 && t_cnt[k] < 6);
      check("d6 ae",        bus6.almostempty, t_cnt[k] >= 1 && t_cnt[k] <= 2);
      check("d6 wr_ack",    bus6.wr_ack, t_wr[k] != 0);
      check("d6 overflow",  bus6.overflow, 0);
      check("d6 underflow", bus6.underflow, 0);
`ifndef SYNC_FIFO_FWFT_EN
      if (t_rdv[k] != 0) check("d6 data", bus6.data_out, 32'h6000 + t_rdv[k]);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
